rvv_xrf_wb_arbiter: RTL and testbench



---
 rtl/rvv_xrf_wb_arbiter_if.sv | 26 ++
 rtl/rvv_xrf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rvv_xrf_wb_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rvv_xrf_wb_arbiter_if.sv
// Retire-slot write-back bus and single rd write port of the scalar-regfile
// write-back arbiter; the arbiter uses the slave modport.
interface rvv_xrf_wb_arbiter_if #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*ADDR_W-1:0] in_addr;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [ADDR_W-1:0]        out_addr;
    logic [DATA_W-1:0]        out_data;
    logic                     out_ready;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/rvv_xrf_wb_arbiter.sv
// In-order merge of NUM_IN retire slots into one rd write port through a DEPTH-entry FIFO.
// Optional same-cycle bypass of slot 0 into an empty FIFO: define XRF_WB_BYPASS_EN.
module rvv_xrf_wb_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    rvv_xrf_wb_arbiter_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         idle
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic [ADDR_W-1:0] slot_addr [NUM_IN];
    logic [DATA_W-1:0] slot_data [NUM_IN];
    logic [PTR_W-1:0]  wr_idx    [NUM_IN];
    logic [NUM_IN-1:0] ready;
    logic [NUM_IN-1:0] wr_en;
    logic [OCC_W-1:0]  enq_cnt;
    logic              fifo_nonempty;
    logic              deq;
    logic              bypass_show;
    logic              bypass_take;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            slot_addr[i] = bus.in_addr[i*ADDR_W +: ADDR_W];
            slot_data[i] = bus.in_data[i*DATA_W +: DATA_W];
            ready[i]     = ((DEPTH - 32'(occ)) > i);
        end
    end

    assign fifo_nonempty = (occ != '0);
    assign deq           = fifo_nonempty && bus.out_ready;

`ifdef XRF_WB_BYPASS_EN
    assign bypass_show = !fifo_nonempty && bus.in_valid[0] && (slot_addr[0] != '0);
`else
    assign bypass_show = 1'b0;
`endif
    assign bypass_take = bypass_show && bus.out_ready;

    // Write slots are packed: x0 targets and a bypassed slot 0 take no position.
    always_comb begin
        enq_cnt = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            wr_idx[i] = wr_ptr + PTR_W'(enq_cnt);
            wr_en[i]  = bus.in_valid[i] && ready[i] && (slot_addr[i] != '0)
                        && !((i == 0) && bypass_take);
            if (wr_en[i]) begin
                enq_cnt = enq_cnt + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            occ    <= occ + enq_cnt - OCC_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) begin
                mem_addr[wr_idx[i]] <= slot_addr[i];
                mem_data[wr_idx[i]] <= slot_data[i];
            end
        end
    end

    // Storage is never reset, so the head entry is masked while the FIFO is empty.
    always_comb begin
        bus.out_valid = fifo_nonempty || bypass_show;
        bus.out_addr  = '0;
        bus.out_data  = '0;
        if (fifo_nonempty) begin
            bus.out_addr = mem_addr[rd_ptr];
            bus.out_data = mem_data[rd_ptr];
        end else if (bypass_show) begin
            bus.out_addr = slot_addr[0];
            bus.out_data = slot_data[0];
        end
    end

    assign bus.in_ready = ready;
    assign occupancy    = occ;
    assign idle         = !fifo_nonempty && (bus.in_valid == '0);

endmodule

// File: tb/tb_rvv_xrf_wb_arbiter.sv
// Directed self-checking bench for rvv_xrf_wb_arbiter (NUM_IN=4, DEPTH=8).
module tb_rvv_xrf_wb_arbiter;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] occ;
    logic       idle;
    int         n_checks = 0;
    int         n_fail   = 0;

    rvv_xrf_wb_arbiter_if #(.NUM_IN(NUM_IN), .ADDR_W(5), .DATA_W(32)) bus ();

    rvv_xrf_wb_arbiter #(.NUM_IN(NUM_IN), .DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .occupancy (occ),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d,
                         input logic rdy);
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  qa [$];
        logic [31:0] qd [$];
        logic [4:0]  exp_a [10];
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rdy;
        logic        push;
        logic        byp;
        logic        acc;
        int          pushes;
        int          cyc;

        rstn = 1'b0;
        drive(4'h0, '0, '0, 1'b0);
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_addr",  bus.out_addr, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_occupancy", occ, 0);
        check("rst_idle",      idle, 1);
        check("rst_in_ready",  bus.in_ready, 4'b1111);
        next_cycle();
        rstn = 1'b1;

        // Four slots in one cycle, then drained one per cycle.
        drive(4'hf, {5'd4, 5'd3, 5'd2, 5'd1},
              {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0);
        check("burst_in_ready", bus.in_ready, 4'b1111);
        check("burst_idle_busy", idle, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(4'h0, '0, '0, 1'b1);
            check("burst_valid", bus.out_valid, 1);
            check("burst_addr", bus.out_addr, 64'(k + 1));
            check("burst_occ", occ, 64'(4 - k));
            next_cycle();
        end
        drive(4'h0, '0, '0, 1'b0);
        check("burst_empty_valid", bus.out_valid, 0);
        check("burst_empty_occ", occ, 0);
        check("burst_empty_idle", idle, 1);

        // Fill to 6, then only two of four slots fit.
        drive(4'hf, {5'd4, 5'd3, 5'd2, 5'd1},
              {32'h3000_0004, 32'h3000_0003, 32'h3000_0002, 32'h3000_0001}, 1'b0);
        next_cycle();
        drive(4'h3, {5'd0, 5'd0, 5'd6, 5'd5}, {64'h0, 32'h3000_0006, 32'h3000_0005}, 1'b0);
        check("fill_occ4", occ, 4);
        next_cycle();
        drive(4'hf, {5'd10, 5'd9, 5'd8, 5'd7},
              {32'h3000_000A, 32'h3000_0009, 32'h3000_0008, 32'h3000_0007}, 1'b0);
        check("fill_occ6", occ, 6);
        check("fill_in_ready", bus.in_ready, 4'b0011);
        next_cycle();
        drive(4'h0, '0, '0, 1'b0);
        check("full_occ", occ, 8);
        check("full_in_ready", bus.in_ready, 4'b0000);
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            drive(4'h0, '0, '0, 1'b1);
            check("full_drain_addr", bus.out_addr, 64'(k + 1));
            check("full_drain_data", bus.out_data, 64'(32'h3000_0000 + k + 1));
            next_cycle();
        end
        drive(4'h3, {5'd0, 5'd0, 5'd10, 5'd9}, {64'h0, 32'h3000_000A, 32'h3000_0009}, 1'b0);
        check("represent_occ", occ, 0);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(4'h0, '0, '0, 1'b1);
            check("represent_addr", bus.out_addr, 64'(k + 9));
            next_cycle();
        end

        // x0 targets consumed but not queued.
        drive(4'hf, {5'd9, 5'd0, 5'd7, 5'd0},
              {32'h0000_0009, 32'h0, 32'h0000_0007, 32'h0}, 1'b0);
        check("x0_in_ready", bus.in_ready, 4'b1111);
        next_cycle();
        exp_a[0] = 5'd7;
        exp_a[1] = 5'd9;
        for (int k = 0; k < 2; k++) begin
            drive(4'h0, '0, '0, 1'b1);
            check("x0_occ", occ, 64'(2 - k));
            check("x0_addr", bus.out_addr, 64'(exp_a[k]));
            next_cycle();
        end
        drive(4'h0, '0, '0, 1'b0);
        check("x0_empty", bus.out_valid, 0);

        // Back-pressure: head holds stable until out_ready.
        drive(4'h1, {15'h0, 5'd3}, {96'h0, 32'h0000_DEAD}, 1'b0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(4'h0, '0, '0, 1'b0);
            check("hold_valid", bus.out_valid, 1);
            check("hold_addr", bus.out_addr, 3);
            check("hold_data", bus.out_data, 32'h0000_DEAD);
            next_cycle();
        end
        drive(4'h0, '0, '0, 1'b1);
        check("hold_release_addr", bus.out_addr, 3);
        next_cycle();
        drive(4'h0, '0, '0, 1'b0);
        check("hold_release_occ", occ, 0);

        // Pointer wrap: 3*DEPTH single-slot pushes with random out_ready against a queue model.
        pushes = 0;
        cyc    = 0;
        while ((pushes < 3 * DEPTH || qa.size() != 0) && cyc < 400) begin
            push = (pushes < 3 * DEPTH);
            rdy  = 1'($urandom_range(0, 1));
            wa   = 5'((pushes % 31) + 1);
            wd   = $urandom;
            drive({3'b000, push}, {15'h0, wa}, {96'h0, wd}, rdy);
`ifdef XRF_WB_BYPASS_EN
            byp = (qa.size() == 0) && push;
`else
            byp = 1'b0;
`endif
            check("wrap_valid", bus.out_valid, 64'((qa.size() != 0) || byp));
            check("wrap_occ", occ, 64'(qa.size()));
            check("wrap_ready0", bus.in_ready[0], 64'(qa.size() < DEPTH));
            if (qa.size() != 0) begin
                check("wrap_addr", bus.out_addr, 64'(qa[0]));
                check("wrap_data", bus.out_data, 64'(qd[0]));
            end else if (byp) begin
                check("wrap_byp_addr", bus.out_addr, 64'(wa));
            end
            acc = push && (qa.size() < DEPTH);
            if ((qa.size() != 0) && rdy) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (acc && !(byp && rdy)) begin
                qa.push_back(wa);
                qd.push_back(wd);
            end
            if (acc) pushes++;
            next_cycle();
            cyc++;
        end
        check("wrap_completed", 64'(cyc < 400), 1);

        // Asynchronous reset with entries queued.
        drive(4'h7, {5'd0, 5'd3, 5'd2, 5'd1}, {32'h0, 32'h3, 32'h2, 32'h1}, 1'b0);
        next_cycle();
        drive(4'h0, '0, '0, 1'b0);
        check("midrst_pre_occ", occ, 3);
        rstn = 1'b0;
        #1;
        check("midrst_occ", occ, 0);
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 4'b1111);
        next_cycle();
        rstn = 1'b1;
        next_cycle();

        // Slot 0 into an empty FIFO with out_ready high.
        drive(4'h1, {15'h0, 5'd5}, {96'h0, 32'h0000_0055}, 1'b1);
`ifdef XRF_WB_BYPASS_EN
        check("byp_same_valid", bus.out_valid, 1);
        check("byp_same_addr", bus.out_addr, 5);
        check("byp_same_data", bus.out_data, 32'h55);
        next_cycle();
        drive(4'h0, '0, '0, 1'b1);
        check("byp_after_occ", occ, 0);
        check("byp_after_valid", bus.out_valid, 0);
`else
        check("nobyp_same_valid", bus.out_valid, 0);
        next_cycle();
        drive(4'h0, '0, '0, 1'b1);
        check("nobyp_t1_valid", bus.out_valid, 1);
        check("nobyp_t1_addr", bus.out_addr, 5);
        check("nobyp_t1_data", bus.out_data, 32'h55);
        check("nobyp_t1_occ", occ, 1);
        next_cycle();
        drive(4'h0, '0, '0, 1'b0);
        check("nobyp_t2_occ", occ, 0);
        check("nobyp_t2_valid", bus.out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
